// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one external combinational ALU between two
//            requesters. A single operation is in flight at a time:
//            IDLE -> EXEC (two cycles) -> RESP -> IDLE.
// Options  : define ALU_ARB_STATS_EN to add saturating per-requester grant
//            counters (grant_cnt0/grant_cnt1).
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [4:0]        req0_op,
   input  logic [31:0]       req0_a,
   input  logic [31:0]       req0_b,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [4:0]        req1_op,
   input  logic [31:0]       req1_a,
   input  logic [31:0]       req1_b,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [31:0]       rsp_result,
   output logic [3:0]        rsp_flags,
`ifdef ALU_ARB_STATS_EN
   output logic [CNT_W-1:0]  grant_cnt0,
   output logic [CNT_W-1:0]  grant_cnt1,
`endif
   output logic [4:0]        alu_ctrl,
   output logic [31:0]       alu_a,
   output logic [31:0]       alu_b,
   input  logic [31:0]       alu_result,
   input  logic [3:0]        alu_flags
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q;
   logic        owner_q;
   logic        rr_next_q;
   logic        exec_ph_q;
   logic [4:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] result_q;
   logic [3:0]  flags_q;
   logic [1:0]  rsp_vld_q;
   logic [1:0]  gnt_d;

   // rr_next_q names the requester favoured when both are valid.
   always_comb begin
      gnt_d = 2'b00;
      if ((state_q == ST_IDLE) && rst_n) begin
         if (req0_valid && req1_valid) begin
            gnt_d = rr_next_q ? 2'b10 : 2'b01;
         end else begin
            gnt_d = {req1_valid, req0_valid};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         owner_q   <= 1'b0;
         rr_next_q <= 1'b0;
         exec_ph_q <= 1'b0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         result_q  <= '0;
         flags_q   <= '0;
         rsp_vld_q <= 2'b00;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (gnt_d != 2'b00) begin
                  owner_q   <= gnt_d[1];
                  rr_next_q <= gnt_d[0];
                  op_q      <= gnt_d[1] ? req1_op : req0_op;
                  a_q       <= gnt_d[1] ? req1_a  : req0_a;
                  b_q       <= gnt_d[1] ? req1_b  : req0_b;
                  exec_ph_q <= 1'b0;
                  state_q   <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // Operands stay stable for two cycles before the ALU output is taken.
               exec_ph_q <= 1'b1;
               if (exec_ph_q) begin
                  result_q  <= alu_result;
                  flags_q   <= alu_flags;
                  rsp_vld_q <= owner_q ? 2'b10 : 2'b01;
                  state_q   <= ST_RESP;
               end
            end
            ST_RESP: begin
               if ((rsp_vld_q & {rsp1_ready, rsp0_ready}) != 2'b00) begin
                  rsp_vld_q <= 2'b00;
                  state_q   <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // The latched operation registers feed the ALU directly, so the ALU inputs
   // only change on acceptance and hold otherwise.
   assign alu_ctrl   = op_q;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign req0_ready = gnt_d[0];
   assign req1_ready = gnt_d[1];
   assign rsp0_valid = rsp_vld_q[0];
   assign rsp1_valid = rsp_vld_q[1];
   assign rsp_result = result_q;
   assign rsp_flags  = flags_q;

`ifdef ALU_ARB_STATS_EN
   logic [CNT_W-1:0] cnt0_q;
   logic [CNT_W-1:0] cnt1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (gnt_d[0] && (cnt0_q != {CNT_W{1'b1}})) begin
            cnt0_q <= cnt0_q + CNT_W'(1);
         end
         if (gnt_d[1] && (cnt1_q != {CNT_W{1'b1}})) begin
            cnt1_q <= cnt1_q + CNT_W'(1);
         end
      end
   end

   assign grant_cnt0 = cnt0_q;
   assign grant_cnt1 = cnt1_q;
`endif

endmodule
`default_nettype wire
